// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: one shift-add or
// shift-subtract step per cycle, sign fix-up on the final step, registered result.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic            i_flush,
  input  logic            i_hold,
  input  logic [2:0]      i_funct_3,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  output logic            o_stall,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
    return ~v + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*XLEN-1:0] neg_w(input logic [2*XLEN-1:0] v);
    return ~v + {{(2*XLEN-1){1'b0}}, 1'b1};
  endfunction

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       funct_r;
  logic [XLEN-1:0]  a_r, b_r, hi_r, lo_r, result_r;
  logic             neg_r, done_r;

  logic             signed_a_s, signed_b_s, sa_s, sb_s, neg_in_s, accept_s;
  logic             div_zero_s, ovf_s, special_s;
  logic [XLEN-1:0]  mag_a_s, mag_b_s, special_res_s;
  logic [XLEN:0]    acc_s, shifted_s, diff_s;
  logic [XLEN-1:0]  step_hi_s, step_lo_s, div_pick_s, div_fix_s, calc_res_s;
  logic [2*XLEN-1:0] prod_s, prod_fix_s;

  // Operand decode: signedness, magnitudes and one-cycle special cases.
  always_comb begin
    signed_a_s = i_funct_3[2] ? ~i_funct_3[0] : (i_funct_3[1:0] != 2'b11);
    signed_b_s = i_funct_3[2] ? ~i_funct_3[0] : ~i_funct_3[1];
    sa_s       = signed_a_s & i_rs1_data[XLEN-1];
    sb_s       = signed_b_s & i_rs2_data[XLEN-1];
    mag_a_s    = sa_s ? neg_x(i_rs1_data) : i_rs1_data;
    mag_b_s    = sb_s ? neg_x(i_rs2_data) : i_rs2_data;
    // Remainder takes the dividend's sign; product and quotient the XOR.
    neg_in_s   = (i_funct_3[2] & i_funct_3[1]) ? sa_s : (sa_s ^ sb_s);
    div_zero_s = i_funct_3[2] & (i_rs2_data == {XLEN{1'b0}});
    ovf_s      = i_funct_3[2] & ~i_funct_3[0] & (i_rs1_data == MIN_INT) &
                 (i_rs2_data == ALL_ONES);
    special_s  = div_zero_s | ovf_s;
    if (div_zero_s) begin
      special_res_s = i_funct_3[1] ? i_rs1_data : ALL_ONES;
    end else begin
      special_res_s = i_funct_3[1] ? {XLEN{1'b0}} : MIN_INT;
    end
    accept_s = (state_r == ST_IDLE) & i_start & ~i_flush;
    o_stall  = i_start & ~i_flush & (state_r != ST_DONE);
  end

  // One iteration step and the sign-fixed result of the final step.
  always_comb begin
    acc_s     = {1'b0, hi_r} + (lo_r[0] ? {1'b0, a_r} : {(XLEN+1){1'b0}});
    shifted_s = {hi_r, lo_r[XLEN-1]};
    diff_s    = shifted_s - {1'b0, b_r};
    if (funct_r[2]) begin
      step_hi_s = diff_s[XLEN] ? shifted_s[XLEN-1:0] : diff_s[XLEN-1:0];
      step_lo_s = {lo_r[XLEN-2:0], ~diff_s[XLEN]};
    end else begin
      step_hi_s = acc_s[XLEN:1];
      step_lo_s = {acc_s[0], lo_r[XLEN-1:1]};
    end
    prod_s     = {step_hi_s, step_lo_s};
    prod_fix_s = neg_r ? neg_w(prod_s) : prod_s;
    div_pick_s = funct_r[1] ? step_hi_s : step_lo_s;
    div_fix_s  = neg_r ? neg_x(div_pick_s) : div_pick_s;
    if (funct_r[2]) begin
      calc_res_s = div_fix_s;
    end else if (funct_r[1:0] == 2'b00) begin
      calc_res_s = prod_fix_s[XLEN-1:0];
    end else begin
      calc_res_s = prod_fix_s[2*XLEN-1:XLEN];
    end
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = special_s ? ST_DONE : ST_CALC;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (i_flush) begin
          state_s = ST_IDLE;
        end else if (cnt_r == LAST_CNT) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_CALC;
        end
      end
      ST_DONE: begin
        if (i_flush) begin
          state_s = ST_IDLE;
        end else if (i_hold) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      funct_r  <= 3'b000;
      a_r      <= {XLEN{1'b0}};
      b_r      <= {XLEN{1'b0}};
      hi_r     <= {XLEN{1'b0}};
      lo_r     <= {XLEN{1'b0}};
      neg_r    <= 1'b0;
      done_r   <= 1'b0;
      result_r <= {XLEN{1'b0}};
    end else begin
      state_r <= state_s;
      done_r  <= (state_s == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            funct_r <= i_funct_3;
            a_r     <= mag_a_s;
            b_r     <= mag_b_s;
            hi_r    <= {XLEN{1'b0}};
            lo_r    <= i_funct_3[2] ? mag_a_s : mag_b_s;
            neg_r   <= neg_in_s;
            cnt_r   <= {CNT_W{1'b0}};
            if (special_s) begin
              result_r <= special_res_s;
            end
          end
        end
        ST_CALC: begin
          if (!i_flush) begin
            hi_r  <= step_hi_s;
            lo_r  <= step_lo_s;
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            if (cnt_r == LAST_CNT) begin
              result_r <= calc_res_s;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_done   = done_r;
  assign o_result = result_r;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed vectors, flush/reset
// sequences and random ops against an arithmetic reference model.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, flush = 1'b0, hold = 1'b0;
  logic [2:0]  funct = 3'b000;
  logic [31:0] rs1 = 32'd0, rs2 = 32'd0;
  logic        stall, done;
  logic [31:0] result;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] last_exp = 32'd0;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_flush(flush), .i_hold(hold),
    .i_funct_3(funct), .i_rs1_data(rs1), .i_rs2_data(rs2),
    .o_stall(stall), .o_done(done), .o_result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          special;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] ea, eb, p;
    int sa, sb;
    sa = a;
    sb = b;
    ea = (f == 3'b011) ? {32'd0, a} : {{32{a[31]}}, a};
    eb = (f == 3'b010 || f == 3'b011) ? {32'd0, b} : {{32{b[31]}}, b};
    p  = ea * eb;
    case (f)
      3'b000:  return p[31:0];
      3'b001, 3'b010, 3'b011: return p[63:32];
      3'b100:  return (b == 32'd0) ? 32'hFFFF_FFFF :
                      (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(sa / sb);
      3'b101:  return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'b110:  return (b == 32'd0) ? a :
                      (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb);
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic bit ref_special(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
    return f[2] && (b == 32'd0 ||
                    (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Present one op in the next cycle, hold start until done, then optionally hold in DONE.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit special, input int hold_n,
                        input string tag);
    int k, stalls, want;
    bit got;
    @(posedge clk); #1;
    start = 1'b1; funct = f; rs1 = a; rs2 = b; hold = 1'b0; flush = 1'b0;
    #1;
    chk({tag, " idle_done"}, {31'd0, done}, 32'd0);
    k = 0; stalls = 0; got = 1'b0;
    want = special ? 1 : 33;
    while (!got && k < 100) begin
      if (done) begin
        got = 1'b1;
      end else begin
        if (stall) stalls++;
        @(posedge clk); #2;
        k++;
      end
    end
    chk({tag, " done_seen"}, {31'd0, got}, 32'd1);
    chk({tag, " done_cycle"}, k, want);
    chk({tag, " stall_cycles"}, stalls, want);
    chk({tag, " stall_at_done"}, {31'd0, stall}, 32'd0);
    chk({tag, " result"}, result, exp);
    last_exp = exp;
    if (hold_n > 0) begin
      hold = 1'b1;
      for (int h = 0; h < hold_n; h++) begin
        @(posedge clk); #2;
        chk({tag, " hold_done"}, {31'd0, done}, 32'd1);
        chk({tag, " hold_result"}, result, exp);
      end
    end
    hold = 1'b0;
    start = 1'b0;
  endtask

  vec_t vecs[$];

  initial begin
    int done_hits;
    logic [2:0]  rf;
    logic [31:0] ra, rb;

    vecs.push_back('{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0});
    vecs.push_back('{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0});
    vecs.push_back('{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0});
    vecs.push_back('{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0});
    vecs.push_back('{3'b000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0});
    vecs.push_back('{3'b100, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 1'b0});
    vecs.push_back('{3'b110, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{3'b100, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0});
    vecs.push_back('{3'b110, 32'd7,          32'hFFFF_FFFE, 32'd1,          1'b0});
    vecs.push_back('{3'b101, 32'd100,        32'd7,          32'd14,         1'b0});
    vecs.push_back('{3'b111, 32'd100,        32'd7,          32'd2,          1'b0});
    vecs.push_back('{3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF, 1'b1});
    vecs.push_back('{3'b111, 32'd5,          32'd0,          32'd5,          1'b1});
    vecs.push_back('{3'b100, 32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFFF, 1'b1});
    vecs.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,          1'b1});
    vecs.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1});

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Directed vectors, back-to-back; the first one held 3 cycles in DONE
    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].special,
             (i == 0) ? 3 : 0, $sformatf("vec%0d", i));
    end

    // Flush at C10: stall drops immediately, no done, result kept
    @(posedge clk); #1;
    start = 1'b1; funct = 3'b100; rs1 = 32'd1000; rs2 = 32'd3;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    #1 chk("flush_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    #1;
    chk("flush_done", {31'd0, done}, 32'd0);
    chk("flush_result", result, last_exp);
    done_hits = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #2;
      if (done) done_hits++;
    end
    chk("flush_no_done", done_hits, 0);
    chk("flush_result_kept", result, last_exp);

    // Reset at C20 aborts and zeroes the outputs
    @(posedge clk); #1;
    start = 1'b1; funct = 3'b000; rs1 = 32'd12345; rs2 = 32'd678;
    repeat (20) @(posedge clk);
    #1 rst = 1'b1; start = 1'b0;
    #1;
    chk("midreset_done", {31'd0, done}, 32'd0);
    chk("midreset_result", result, 32'd0);
    chk("midreset_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    last_exp = 32'd0;

    // Next op after abort runs clean, then DIVU followed directly by MUL
    run_op(3'b000, 32'd12345, 32'd678, 32'd8369910, 1'b0, 0, "post_reset");
    run_op(3'b101, 32'd1000, 32'd3, 32'd333, 1'b0, 0, "b2b_divu");
    run_op(3'b000, 32'd1000, 32'd3, 32'd3000, 1'b0, 2, "b2b_mul");

    // Randomized ops against the reference model
    for (int r = 0; r < 40; r++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 9));
        3: ra = 32'hFFFF_FFFF;
        default: begin end
      endcase
      run_op(rf, ra, rb, ref_model(rf, ra, rb), ref_special(rf, ra, rb),
             int'($urandom_range(0, 2)), $sformatf("rnd%0d_f%0d", r, rf));
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
